// File: rtl/assay_pkg.sv
// Shared types and default constants for the protein-assay optical readout.
package assay_pkg;

  localparam int unsigned N_CH_DEF     = 8;
  localparam int unsigned DW_DEF       = 12;
  localparam int unsigned AVG_LOG2_DEF = 4;
  localparam int unsigned SETTLE_DEF   = 8;
  localparam int unsigned TIMEOUT_DEF  = 255;

  localparam int unsigned CH_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACQ    = 3'd2,
    ST_EMIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/avg_accum.sv
// Sample accumulator and counter for one channel; result is the truncating average.
module avg_accum
  import assay_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                add,
  input  logic [DW-1:0]       din,
  output logic [AVG_LOG2:0]   count,
  output logic [DW-1:0]       result
);

  localparam int unsigned AW = DW + AVG_LOG2;
  localparam int unsigned CW = AVG_LOG2 + 1;

  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // next accumulator / sample count
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      acc_d = {AW{1'b0}};
      cnt_d = {CW{1'b0}};
    end else if (add) begin
      acc_d = acc_q + AW'(din);
      cnt_d = cnt_q + CW'(1);
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= {AW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign count  = cnt_q;
  assign result = DW'(acc_q >> AVG_LOG2);

endmodule

// File: rtl/assay_readout.sv
// Scans the optical channels in order, averages ADC samples per channel and
// hands each result downstream over a valid/ready port.
module assay_readout
  import assay_pkg::*;
#(
  parameter int unsigned N_CH     = N_CH_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF,
  parameter int unsigned SETTLE   = SETTLE_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            adc_valid,
  input  logic [DW-1:0]   adc_data,
  output logic [CH_W-1:0] ch_sel,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [CH_W-1:0] res_ch,
  output logic [DW-1:0]   res_data,
  output logic            res_err,
  output logic            busy,
  output logic            done
);

  localparam int unsigned SET_W = $clog2(SETTLE + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned CW    = AVG_LOG2 + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
  localparam logic [CW-1:0]   N_SAMP  = CW'(2 ** AVG_LOG2);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;
  logic [DW-1:0]     res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              acc_clear_s, acc_add_s, acc_full_s;
  logic [CW-1:0]     acc_count_s;
  logic [DW-1:0]     acc_result_s;

  // accumulator only runs in ACQ, so settle-time samples never reach it
  assign acc_full_s  = (acc_count_s == N_SAMP);
  assign acc_clear_s = (state_q != ST_ACQ);
  assign acc_add_s   = (state_q == ST_ACQ) && adc_valid && !acc_full_s;

  avg_accum #(
    .DW       (DW),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg_accum (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clear_s),
    .add    (acc_add_s),
    .din    (adc_data),
    .count  (acc_count_s),
    .result (acc_result_s)
  );

  // next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    ch_sel_d     = ch_sel_q;
    settle_cnt_d = settle_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    res_ch_d     = res_ch_q;
    res_data_d   = res_data_q;
    res_err_d    = res_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ch_sel_d     = {CH_W{1'b0}};
          settle_cnt_d = {SET_W{1'b0}};
          state_d      = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        wait_cnt_d = {TO_W{1'b0}};
        if (settle_cnt_q == SET_W'(SETTLE - 1)) begin
          settle_cnt_d = {SET_W{1'b0}};
          state_d      = ST_ACQ;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      ST_ACQ: begin
        if (acc_full_s) begin
          res_ch_d   = ch_sel_q;
          res_data_d = acc_result_s;
          res_err_d  = 1'b0;
          state_d    = ST_EMIT;
        end else if (adc_valid) begin
          wait_cnt_d = {TO_W{1'b0}};
        end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
          // starved detector: still report the channel, flagged invalid
          res_ch_d   = ch_sel_q;
          res_data_d = {DW{1'b0}};
          res_err_d  = 1'b1;
          state_d    = ST_EMIT;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      ST_EMIT: begin
        if (res_ready) begin
          if (ch_sel_q < LAST_CH) begin
            ch_sel_d     = ch_sel_q + CH_W'(1);
            settle_cnt_d = {SET_W{1'b0}};
            state_d      = ST_SETTLE;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_EMIT);
    done_d      = (state_d == ST_DONE);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ch_sel_q     <= {CH_W{1'b0}};
      settle_cnt_q <= {SET_W{1'b0}};
      wait_cnt_q   <= {TO_W{1'b0}};
      res_ch_q     <= {CH_W{1'b0}};
      res_data_q   <= {DW{1'b0}};
      res_err_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_sel_q     <= ch_sel_d;
      settle_cnt_q <= settle_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      res_ch_q     <= res_ch_d;
      res_data_q   <= res_data_d;
      res_err_q    <= res_err_d;
      res_valid_q  <= res_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ch_sel    = ch_sel_q;
  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
